pll_reset_ctrl: RTL and testbench
=================================

Name: pll_reset_ctrl

Overview:
- Reset and lock sequencer for the clock PLL. Runs on the 50 MHz board reference clock, so it keeps working while the PLL is unlocked.
- Drives the PLL's `rst` input and consumes its asynchronous `locked` output.
- Produces a clean system reset and ready flag once lock has been stable for a programmed time.
- Re-sequences the PLL on lock loss, lock timeout or software request. Core-domain resynchronisation of `sys_rst` is done downstream.

Parameters:
- LOCK_SYNC_STAGES, 2, synchroniser depth for `pll_locked` (minimum 2).
- PLL_RST_CYCLES, 16, refclk cycles `pll_rst` is held high per attempt.
- LOCK_TIMEOUT, 50000, refclk cycles allowed in WAIT_LOCK before retrying (1 ms).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before RUN.
- RELOCK_CNT_W, 8, width of the relock event counter.

Ports:
- refclk  in  1  board reference clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indicator, asynchronous to refclk.
- soft_rst_req  in  1  single-cycle software request to re-sequence the PLL.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  system reset, active-high.
- ready  out  1  high only in RUN.
- relock_count  out  RELOCK_CNT_W  saturating count of lock losses seen in RUN.
- timeout_err  out  1  sticky flag: at least one lock timeout has occurred.

Behaviour:
- Reset is asynchronous and active-high. The clock is `refclk` and the reset is `rst`.
- Reset values:
  - state = PLL_RESET
  - pll_rst = 1, sys_rst = 1, ready = 0
  - relock_count = 0, timeout_err = 0
  - cycle counter = 0, synchroniser flops = 0
- `pll_locked` passes through a LOCK_SYNC_STAGES flop chain to give `lock_s`. Nothing else uses the raw input.
- One cycle counter is shared by all states. Its width is `$clog2` of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT and LOCK_STABLE_CYCLES. It clears on every state change.
- States and transitions:
  - PLL_RESET: counter increments each cycle. At count PLL_RST_CYCLES-1, go to WAIT_LOCK. `soft_rst_req` is ignored here.
  - WAIT_LOCK:
    - If `lock_s` = 1, go to STABLE.
    - Otherwise, at count LOCK_TIMEOUT-1, go to PLL_RESET and set `timeout_err`.
    - `soft_rst_req` goes to PLL_RESET.
  - STABLE:
    - If `lock_s` = 0, go to WAIT_LOCK; `relock_count` does not change.
    - Otherwise, at count LOCK_STABLE_CYCLES-1, go to RUN.
    - `soft_rst_req` goes to PLL_RESET.
  - RUN:
    - If `lock_s` = 0, go to PLL_RESET and increment `relock_count`, saturating at all-ones.
    - Otherwise, `soft_rst_req` goes to PLL_RESET with no increment.
- Simultaneous events:
  - Lock loss has priority over `soft_rst_req` in RUN; the count still increments.
  - In STABLE, lock loss has priority over `soft_rst_req`.
  - In WAIT_LOCK, lock arriving has priority over timeout.
- Outputs are registered, decoded from the next state, so they align with the state register:
  - pll_rst = (state == PLL_RESET)
  - sys_rst = (state != RUN)
  - ready = (state == RUN)
- Latency:
  - From `rst` release with `pll_locked` already high, `ready` rises after PLL_RST_CYCLES + LOCK_SYNC_STAGES + LOCK_STABLE_CYCLES cycles, ±1.
  - A `pll_locked` fall in RUN asserts `sys_rst` and `pll_rst` at edge LOCK_SYNC_STAGES+1.
- `timeout_err` clears only on `rst`.
- `rst` asserted mid-operation returns everything to reset values immediately. `relock_count` is lost.

Optional Feature:
- Macro PLL_RESET_CTRL_GLITCH_FILTER_EN.
- Defined: in RUN, `lock_s` must be 0 for 4 consecutive cycles before leaving RUN. A shorter low pulse is ignored and the filter counter clears when `lock_s` returns to 1. Lock-loss latency becomes LOCK_SYNC_STAGES+4.
- Undefined: a single-cycle `lock_s` low acts immediately.
- STABLE and WAIT_LOCK behaviour is identical either way.

Test Plan:
- Bench overrides: PLL_RST_CYCLES=16, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=100.
- Power-up with `pll_locked` tied high, release `rst` -> `pll_rst` high exactly 16 cycles; `ready` = 1 and `sys_rst` = 0 about 26 cycles after release; `relock_count` = 0.
- `pll_locked` held low -> `pll_rst` re-pulses for 16 cycles every 116 cycles; `timeout_err` = 1 after the first timeout and stays set after lock is later achieved.
- In RUN, drop `pll_locked` for 10 cycles, three times -> `sys_rst` asserted 3 cycles after each drop; `relock_count` = 3; `ready` returns each time.
- In STABLE, drop lock at count 5 -> back to WAIT_LOCK, no `pll_rst` pulse, `relock_count` unchanged; full 8-cycle stable window required again.
- In RUN, assert `soft_rst_req` and a lock drop on the same synchronised cycle -> single PLL_RESET entry, `relock_count` +1. `soft_rst_req` alone -> PLL_RESET with count unchanged.
- `rst` asserted mid-WAIT_LOCK with `relock_count` = 5 and `timeout_err` = 1 -> all outputs at reset values asynchronously. With PLL_RESET_CTRL_GLITCH_FILTER_EN defined, a 2-cycle lock drop in RUN is ignored and a 4-cycle drop re-sequences.

Source files
------------

// File: rtl/pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// pll_reset_ctrl
//
// Reset and lock sequencer for the clock PLL. Runs on the board reference
// clock so it keeps sequencing while the PLL is unlocked. It pulses the PLL
// reset, waits for a synchronised lock, and requires lock to be stable for a
// programmed window before releasing the system reset and raising ready.
// Lock loss, lock timeout or a software request re-sequence the PLL.
//
// Optional build macro:
//   PLL_RESET_CTRL_GLITCH_FILTER_EN - in RUN, lock must read low for 4
//   consecutive refclk cycles before it counts as lost. Shorter low pulses
//   are ignored. Without the macro, one low cycle in RUN acts immediately.
//
// Ports:
//   refclk        in   board reference clock (50 MHz)
//   rst           in   asynchronous active-high reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   soft_rst_req  in   single-cycle software request to re-sequence the PLL
//   pll_rst       out  reset to the PLL, active-high
//   sys_rst       out  system reset, active-high (high unless in RUN)
//   ready         out  high only in RUN
//   relock_count  out  saturating count of lock losses seen in RUN
//   timeout_err   out  sticky: at least one lock timeout has occurred
// -----------------------------------------------------------------------------
module pll_reset_ctrl #(
    parameter int LOCK_SYNC_STAGES   = 2,      // minimum 2
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 50000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RELOCK_CNT_W       = 8
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    soft_rst_req,
    output logic                    pll_rst,
    output logic                    sys_rst,
    output logic                    ready,
    output logic [RELOCK_CNT_W-1:0] relock_count,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABLE,
        RUN
    } state_e;

    // One counter serves every state, so it is sized for the longest wait.
    localparam int CNT_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (CNT_A > LOCK_STABLE_CYCLES) ? CNT_A : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOUT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
    logic                    timeout_q, timeout_d;
    logic                    pll_rst_q, sys_rst_q, ready_q;
    logic [LOCK_SYNC_STAGES-1:0] sync_q;
    logic                    lock_s;
    logic                    run_lock_lost;

    // Synchroniser for the asynchronous lock indicator; only lock_s is used.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchroniser chain into a single flop.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

`ifdef PLL_RESET_CTRL_GLITCH_FILTER_EN
    // Counts consecutive low lock_s cycles in RUN; lock is lost on the 4th.
    logic [1:0] filt_q, filt_d;

    assign run_lock_lost = ~lock_s & (filt_q == 2'd3);

    always_comb begin
        filt_d = 2'd0;
        if (state_d == RUN && !lock_s) begin
            filt_d = filt_q + 2'd1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            filt_q <= 2'd0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    assign run_lock_lost = ~lock_s;
`endif

    // Next-state logic.
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        relock_d  = relock_q;
        timeout_d = timeout_q;

        case (state_q)
            PLL_RESET: begin
                // Software requests are ignored: the PLL is already in reset.
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                // Lock arriving wins over a coincident timeout.
                if (lock_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TOUT_LAST) begin
                    state_d   = PLL_RESET;
                    timeout_d = 1'b1;
                end else if (soft_rst_req) begin
                    state_d = PLL_RESET;
                end
            end
            STABLE: begin
                // A lock drop restarts the wait without re-resetting the PLL.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (soft_rst_req) begin
                    state_d = PLL_RESET;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Lock loss wins over a coincident software request so the
                // event is still counted.
                if (run_lock_lost) begin
                    state_d = PLL_RESET;
                    if (relock_q != {RELOCK_CNT_W{1'b1}}) begin
                        relock_d = relock_q + RELOCK_CNT_W'(1);
                    end
                end else if (soft_rst_req) begin
                    state_d = PLL_RESET;
                end
            end
            default: state_d = PLL_RESET;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= PLL_RESET;
            cnt_q     <= '0;
            relock_q  <= '0;
            timeout_q <= 1'b0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            relock_q  <= relock_d;
            timeout_q <= timeout_d;
            pll_rst_q <= (state_d == PLL_RESET);
            sys_rst_q <= (state_d != RUN);
            ready_q   <= (state_d == RUN);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_ctrl
//
// Directed and randomised bench for pll_reset_ctrl. A phase-level reference
// model (lock delay line, phase id, time-in-phase) predicts all outputs after
// every refclk edge; directed steps add latency and sequencing checks.
// -----------------------------------------------------------------------------
module tb_pll_reset_ctrl;

    localparam int SYNC = 2;
    localparam int PRST = 16;
    localparam int TOUT = 100;
    localparam int STAB = 8;
    localparam int RW   = 8;

    localparam int PH_RST  = 0;
    localparam int PH_WAIT = 1;
    localparam int PH_STAB = 2;
    localparam int PH_RUN  = 3;

    localparam int SEL_READY = 0;
    localparam int SEL_PRST  = 1;
    localparam int SEL_SYS   = 2;

`ifdef PLL_RESET_CTRL_GLITCH_FILTER_EN
    localparam int LOSS_LOW = 4;
`else
    localparam int LOSS_LOW = 1;
`endif
    // A fall of pll_locked in RUN reaches sys_rst after the synchroniser plus
    // the number of low cycles needed to declare the loss.
    localparam int DROP_LAT = SYNC + LOSS_LOW;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          soft_rst_req = 1'b0;
    logic          pll_rst, sys_rst, ready, timeout_err;
    logic [RW-1:0] relock_count;

    int total = 0;
    int bad   = 0;

    pll_reset_ctrl #(
        .LOCK_SYNC_STAGES  (SYNC),
        .PLL_RST_CYCLES    (PRST),
        .LOCK_TIMEOUT      (TOUT),
        .LOCK_STABLE_CYCLES(STAB),
        .RELOCK_CNT_W      (RW)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .soft_rst_req(soft_rst_req),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .relock_count(relock_count),
        .timeout_err (timeout_err)
    );

    always #10 refclk = ~refclk;

    // ---------------- reference model ----------------
    int m_phase;
    int m_time;      // cycles already spent in the current phase
    int m_low;       // consecutive low synchronised-lock cycles in RUN
    int m_relock;
    bit m_terr;
    bit m_hist[$];   // raw lock samples still travelling through the synchroniser

    task automatic model_reset();
        m_phase  = PH_RST;
        m_time   = 0;
        m_low    = 0;
        m_relock = 0;
        m_terr   = 1'b0;
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    endtask

    task automatic model_edge(input bit pl, input bit sr);
        bit ls;
        int nxt;
        ls = m_hist[0];
        m_hist.pop_front();
        m_hist.push_back(pl);
        nxt = m_phase;
        m_low = (m_phase == PH_RUN && !ls) ? m_low + 1 : 0;
        if (m_phase == PH_RST) begin
            if (m_time + 1 >= PRST) nxt = PH_WAIT;
        end else if (m_phase == PH_WAIT) begin
            if (ls) nxt = PH_STAB;
            else if (m_time + 1 >= TOUT) begin
                nxt = PH_RST;
                m_terr = 1'b1;
            end else if (sr) nxt = PH_RST;
        end else if (m_phase == PH_STAB) begin
            if (!ls) nxt = PH_WAIT;
            else if (sr) nxt = PH_RST;
            else if (m_time + 1 >= STAB) nxt = PH_RUN;
        end else begin
            if (m_low >= LOSS_LOW) begin
                nxt = PH_RST;
                if (m_relock < (1 << RW) - 1) m_relock++;
            end else if (sr) nxt = PH_RST;
        end
        if (nxt != m_phase) begin
            m_time = 0;
            m_low  = 0;
        end else begin
            m_time++;
        end
        m_phase = nxt;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_val("mdl_pll_rst", {31'd0, pll_rst}, {31'd0, m_phase == PH_RST});
        check_val("mdl_sys_rst", {31'd0, sys_rst}, {31'd0, m_phase != PH_RUN});
        check_val("mdl_ready", {31'd0, ready}, {31'd0, m_phase == PH_RUN});
        check_val("mdl_relock", {24'd0, relock_count}, m_relock);
        check_val("mdl_timeout_err", {31'd0, timeout_err}, {31'd0, m_terr});
    endtask

    // One refclk edge: advance the model with the inputs seen at the edge,
    // then compare #1 later.
    task automatic tick();
        @(posedge refclk);
        if (rst) model_reset();
        else model_edge(pll_locked, soft_rst_req);
        #1;
        check_outputs();
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            SEL_READY: return ready;
            SEL_PRST:  return pll_rst;
            default:   return sys_rst;
        endcase
    endfunction

    // Ticks until the selected output reaches level; n = ticks taken.
    task automatic wait_sig(input string tag, input int sel, input bit level,
                            input int budget, output int n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            tick();
            n++;
            hit = (pick(sel) === level);
        end
        if (!hit) begin
            total++;
            bad++;
            $error("FAIL %s: observed=no change expected=level %0d within %0d cycles", tag, level, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int fall_at;
        int ready_at;
        int rises;
        int prst_seen;
        int exp_rc;
        int len;
        bit prev;

        model_reset();
        exp_rc = 0;

        // Power-up with lock already high.
        rst        = 1'b1;
        pll_locked = 1'b1;
        repeat (3) tick();
        check_val("rst_pll_rst", {31'd0, pll_rst}, 1);
        check_val("rst_sys_rst", {31'd0, sys_rst}, 1);
        check_val("rst_ready", {31'd0, ready}, 0);
        check_val("rst_relock", {24'd0, relock_count}, 0);
        check_val("rst_timeout_err", {31'd0, timeout_err}, 0);

        rst      = 1'b0;
        fall_at  = -1;
        ready_at = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (!pll_rst && fall_at < 0) fall_at = c;
            if (ready && ready_at < 0) ready_at = c;
        end
        check_val("pwrup_pll_rst_len", fall_at, PRST);
        // Lock is already synchronised when PLL_RESET ends: one WAIT cycle.
        check_val("pwrup_ready_at", ready_at, PRST + 1 + STAB);
        check_val("pwrup_sys_rst", {31'd0, sys_rst}, 0);
        check_val("pwrup_relock", {24'd0, relock_count}, 0);

        // Three 10-cycle lock drops in RUN.
        for (int k = 0; k < 3; k++) begin
            pll_locked = 1'b0;
            wait_sig("drop_sys_rst", SEL_SYS, 1'b1, 20, n);
            check_val("drop_latency", n, DROP_LAT);
            check_val("drop_pll_rst", {31'd0, pll_rst}, 1);
            repeat (10 - n) tick();
            pll_locked = 1'b1;
            wait_sig("drop_ready_back", SEL_READY, 1'b1, 200, n);
        end
        exp_rc = 3;
        check_val("drop_relock_3", {24'd0, relock_count}, exp_rc);

        // Software request on the same synchronised cycle as a lock drop.
        pll_locked = 1'b0;
        rises      = 0;
        prev       = pll_rst;
        for (int c = 0; c < 60; c++) begin
            soft_rst_req = (c == SYNC);
            tick();
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
            if (c == 9) pll_locked = 1'b1;
        end
        soft_rst_req = 1'b0;
        check_val("simul_single_reset", rises, 1);
`ifndef PLL_RESET_CTRL_GLITCH_FILTER_EN
        // The loss is declared on that cycle and wins over the request.
        exp_rc = exp_rc + 1;
`endif
        check_val("simul_relock", {24'd0, relock_count}, exp_rc);
        wait_sig("simul_ready", SEL_READY, 1'b1, 200, n);

        // Software request alone.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        check_val("soft_pll_rst", {31'd0, pll_rst}, 1);
        check_val("soft_ready", {31'd0, ready}, 0);
        check_val("soft_relock", {24'd0, relock_count}, exp_rc);

        // Lock drop seen at STABLE count 5.
        wait_sig("stab_enter_wait", SEL_PRST, 1'b0, 40, n);
        tick();               // lock_s high: STABLE entered, count 0
        repeat (3) tick();
        pll_locked = 1'b0;
        prst_seen  = 0;
        repeat (4) begin
            tick();
            if (pll_rst) prst_seen++;
        end
        pll_locked = 1'b1;
        ready_at   = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (pll_rst) prst_seen++;
            if (ready && ready_at < 0) ready_at = c;
        end
        check_val("stab_no_pll_rst", prst_seen, 0);
        check_val("stab_full_window", ready_at, SYNC + 1 + STAB);
        check_val("stab_relock", {24'd0, relock_count}, exp_rc);

        // Lock lost for good: re-pulse every PRST+TOUT cycles.
        pll_locked = 1'b0;
        wait_sig("to_first_reset", SEL_PRST, 1'b1, 20, n);
        exp_rc = exp_rc + 1;
        check_val("to_relock", {24'd0, relock_count}, exp_rc);
        wait_sig("to_pulse1_end", SEL_PRST, 1'b0, 40, n);
        check_val("to_pulse1_len", n, PRST);
        check_val("to_err_before", {31'd0, timeout_err}, 0);
        wait_sig("to_pulse2_start", SEL_PRST, 1'b1, 200, n);
        check_val("to_wait1_len", n, TOUT);
        check_val("to_err_after", {31'd0, timeout_err}, 1);
        wait_sig("to_pulse2_end", SEL_PRST, 1'b0, 40, n);
        check_val("to_pulse2_len", n, PRST);
        wait_sig("to_pulse3_start", SEL_PRST, 1'b1, 200, n);
        check_val("to_wait2_len", n, TOUT);

        // Lock finally arrives: timeout_err stays set.
        pll_locked = 1'b1;
        wait_sig("to_lock_ready", SEL_READY, 1'b1, 200, n);
        check_val("to_err_sticky", {31'd0, timeout_err}, 1);

        // Asynchronous reset in the middle of WAIT_LOCK.
        soft_rst_req = 1'b1;
        tick();
        soft_rst_req = 1'b0;
        pll_locked   = 1'b0;
        wait_sig("ar_enter_wait", SEL_PRST, 1'b0, 40, n);
        repeat (10) tick();
        check_val("ar_pre_relock", {24'd0, relock_count}, exp_rc);
        check_val("ar_pre_err", {31'd0, timeout_err}, 1);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_val("ar_pll_rst", {31'd0, pll_rst}, 1);
        check_val("ar_sys_rst", {31'd0, sys_rst}, 1);
        check_val("ar_ready", {31'd0, ready}, 0);
        check_val("ar_relock", {24'd0, relock_count}, 0);
        check_val("ar_timeout_err", {31'd0, timeout_err}, 0);
        repeat (2) tick();

        // Short and 4-cycle lock drops in RUN.
        pll_locked = 1'b1;
        rst        = 1'b0;
        exp_rc     = 0;
        wait_sig("gl_ready", SEL_READY, 1'b1, 60, n);
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
`ifndef PLL_RESET_CTRL_GLITCH_FILTER_EN
        exp_rc = exp_rc + 1;
`endif
        check_val("gl_short_relock", {24'd0, relock_count}, exp_rc);
        wait_sig("gl_short_ready", SEL_READY, 1'b1, 60, n);
        pll_locked = 1'b0;
        repeat (4) tick();
        pll_locked = 1'b1;
        repeat (10) tick();
        exp_rc = exp_rc + 1;
        check_val("gl_long_relock", {24'd0, relock_count}, exp_rc);
        wait_sig("gl_long_ready", SEL_READY, 1'b1, 60, n);

        // Randomised lock behaviour and software requests against the model.
        for (int seg = 0; seg < 70; seg++) begin
            if ($urandom_range(0, 9) == 0) len = $urandom_range(100, 160);
            else len = $urandom_range(1, 30);
            pll_locked = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < len; c++) begin
                soft_rst_req = ($urandom_range(0, 39) == 0);
                tick();
            end
        end
        soft_rst_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
